// File: rtl/rcpa_adder16_if.sv
// ============================================================================
// Module  : rcpa_adder16_if
// Brief   : Operand/result bundle for the ripple-carry adder primitive.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface rcpa_adder16_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic [WIDTH-1:0] s_q;
   logic             cout_q;
   logic             ovf_q;

   modport master (
      output a, b, cin,
      input  s, cout, s_q, cout_q, ovf_q
   );

   modport slave (
      input  a, b, cin,
      output s, cout, s_q, cout_q, ovf_q
   );
endinterface

`default_nettype wire

// File: rtl/rcpa_adder16.sv
// ============================================================================
// Module  : rcpa_adder16
// Brief   : WIDTH-bit ripple-carry adder with registered sum/carry/overflow.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rcpa_fa_cell (
   input  wire logic a_i,
   input  wire logic b_i,
   input  wire logic c_i,
   output logic      s_o,
   output logic      c_o
);
   logic prop;

   assign prop = a_i ^ b_i;
   assign s_o  = prop ^ c_i;
   assign c_o  = (a_i & b_i) | (c_i & prop);
endmodule

module rcpa_adder16 #(
   parameter int WIDTH = 16
) (
   input  wire logic     clk,
   input  wire logic     rst,
   rcpa_adder16_if.slave io
);
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum;
   logic [WIDTH:0]   carry;
   logic             ovf;

   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             ovf_q;
   logic [WIDTH-1:0] sum_d;
   logic             carry_d;
   logic             ovf_d;

   assign op_a     = io.a;
   assign op_b     = io.b;
   assign carry[0] = io.cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      rcpa_fa_cell u_fa (
         .a_i (op_a[i]),
         .b_i (op_b[i]),
         .c_i (carry[i]),
         .s_o (sum[i]),
         .c_o (carry[i+1])
      );
   end

   // Carries into and out of the sign bit disagree exactly on signed overflow.
   assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

   assign sum_d   = sum;
   assign carry_d = carry[WIDTH];
   assign ovf_d   = ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign io.s      = sum;
   assign io.cout   = carry[WIDTH];
   assign io.s_q    = sum_q;
   assign io.cout_q = carry_q;
   assign io.ovf_q  = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_rcpa_adder16.sv
// ============================================================================
// Module  : tb_rcpa_adder16
// Brief   : Directed-vector, sweep, reset and random checks for rcpa_adder16.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rcpa_adder16;
   localparam int WIDTH = 16;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        cout;
      logic        ovf;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   rcpa_adder16_if #(.WIDTH(WIDTH)) bus ();

   rcpa_adder16 #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin);
      bus.a   = a;
      bus.b   = b;
      bus.cin = cin;
   endtask

   vec_t vecs [12];
   logic [15:0] av [3];
   logic [15:0] bv [3];

   initial begin
      logic [16:0] ref_sum;
      logic        ref_ovf;
      logic [15:0] ra, rb;
      logic        rc;

      checks   = 0;
      failures = 0;

      vecs[0]  = '{16'h158A, 16'h7095, 1'b0, 16'h861F, 1'b0, 1'b1};
      vecs[1]  = '{16'h158A, 16'h7095, 1'b1, 16'h8620, 1'b0, 1'b1};
      vecs[2]  = '{16'h52AF, 16'hC6BD, 1'b0, 16'h196C, 1'b1, 1'b0};
      vecs[3]  = '{16'h158A, 16'h9A4E, 1'b0, 16'hAFD8, 1'b0, 1'b0};
      vecs[4]  = '{16'hB903, 16'h7095, 1'b0, 16'h2998, 1'b1, 1'b0};
      vecs[5]  = '{16'hB903, 16'h9A4E, 1'b0, 16'h5351, 1'b1, 1'b1};
      vecs[6]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[8]  = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
      vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[11] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};

      av[0] = 16'h158A; av[1] = 16'h52AF; av[2] = 16'hB903;
      bv[0] = 16'h7095; bv[1] = 16'hC6BD; bv[2] = 16'h9A4E;

      // Reset state and power-up with rst held high over edges.
      rst = 1'b1;
      drive(16'h158A, 16'h7095, 1'b0);
      @(posedge clk); #1;
      check("reset_s_q",    32'(bus.s_q),    32'h0);
      check("reset_cout_q", 32'(bus.cout_q), 32'h0);
      check("reset_ovf_q",  32'(bus.ovf_q),  32'h0);
      check("reset_comb_s", 32'(bus.s),      32'h861F);
      @(negedge clk);
      rst = 1'b0;

      // Directed table: combinational result, then registered copy one edge later.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(vecs[i].a, vecs[i].b, vecs[i].cin);
         #1;
         check($sformatf("vec%0d_s", i),    32'(bus.s),    32'(vecs[i].s));
         check($sformatf("vec%0d_cout", i), 32'(bus.cout), 32'(vecs[i].cout));
         @(posedge clk); #1;
         check($sformatf("vec%0d_s_q", i),    32'(bus.s_q),    32'(vecs[i].s));
         check($sformatf("vec%0d_cout_q", i), 32'(bus.cout_q), 32'(vecs[i].cout));
         check($sformatf("vec%0d_ovf_q", i),  32'(bus.ovf_q),  32'(vecs[i].ovf));
      end

      // Mid-cycle async reset: registers clear at once, comb path keeps tracking.
      @(negedge clk);
      drive(16'h158A, 16'h7095, 1'b0);
      @(posedge clk); #2;
      check("pre_rst_s_q", 32'(bus.s_q), 32'h861F);
      rst = 1'b1;
      #1;
      check("async_rst_s_q",    32'(bus.s_q),    32'h0);
      check("async_rst_cout_q", 32'(bus.cout_q), 32'h0);
      check("async_rst_ovf_q",  32'(bus.ovf_q),  32'h0);
      drive(16'h52AF, 16'hC6BD, 1'b0);
      #1;
      check("rst_comb_s",    32'(bus.s),    32'h196C);
      check("rst_comb_cout", 32'(bus.cout), 32'h1);
      @(posedge clk); #1;
      check("rst_hold_s_q", 32'(bus.s_q), 32'h0);
      @(negedge clk);
      drive(16'h158A, 16'h7095, 1'b0);
      rst = 1'b0;
      #1;
      check("post_rel_s_q", 32'(bus.s_q), 32'h0);
      @(posedge clk); #1;
      check("first_cap_s_q",    32'(bus.s_q),    32'h861F);
      check("first_cap_cout_q", 32'(bus.cout_q), 32'h0);
      check("first_cap_ovf_q",  32'(bus.ovf_q),  32'h1);

      // Sweep: cin every 10ns, b every 20ns, a every 60ns.
      for (int t = 0; t < 18; t++) begin
         drive(av[(t / 6) % 3], bv[(t / 2) % 3], 1'(t % 2));
         #1;
         ref_sum = {1'b0, bus.a} + {1'b0, bus.b} + {16'h0, bus.cin};
         check($sformatf("sweep%0d", t), 32'({bus.cout, bus.s}), 32'(ref_sum));
         #9;
      end

      // Random vectors; overflow model uses the sign rule rather than carries.
      for (int n = 0; n < 10000; n++) begin
         @(negedge clk);
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         drive(ra, rb, rc);
         #1;
         ref_sum = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
         ref_ovf = (ra[15] == rb[15]) && (ref_sum[15] != ra[15]);
         check("rand_comb", 32'({bus.cout, bus.s}), 32'(ref_sum));
         @(posedge clk); #1;
         check("rand_reg", 32'({bus.ovf_q, bus.cout_q, bus.s_q}), 32'({ref_ovf, ref_sum}));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
